score_bcd: RTL

Four-digit BCD score keeper for the flappy-bird game: counts pipe-pass events, freezes on game over, keeps a best score, and drives the `points_3..points_0` digit inputs of the seven-segment display driver. Sits between the game-logic FSM, which produces event levels, and `sevenseg`, which consumes the digit values. All state is in the `score_clk` domain.

---
 rtl/score_bcd.sv | 70 +++++++
 1 files changed

// File: rtl/score_bcd.sv
// score_bcd: four-digit BCD score keeper with round freeze, best score and digit mux
module score_bcd (
    input  logic       score_clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       game_over,
    input  logic       new_game,
    input  logic       show_high,
    output logic [3:0] points_3,
    output logic [3:0] points_2,
    output logic [3:0] points_1,
    output logic [3:0] points_0,
    output logic       saturated,
    output logic       new_high,
    output logic       playing
);
    typedef enum logic {PLAY, OVER} state_t;
    state_t      state, state_nx;
    logic [15:0] score, high, score_nx, high_nx, score_inc, cand, disp;
    logic        inc_q, go_q, new_high_nx, inc_rise, go_rise, c;
    assign inc_rise  = inc & ~inc_q;
    assign go_rise   = game_over & ~go_q;
    assign saturated = score == 16'h9999;
    assign playing   = state == PLAY;
    always_comb begin
        score_inc = score;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            score_inc[4*i +: 4] = c ? (score[4*i +: 4] == 4'd9 ? 4'd0 : score[4*i +: 4] + 4'd1) : score[4*i +: 4];
            c = c && score[4*i +: 4] == 4'd9;
        end
    end
    assign cand = inc_rise && !saturated ? score_inc : score;
    always_comb begin
        state_nx    = state;
        score_nx    = score;
        high_nx     = high;
        new_high_nx = new_high;
        if (new_game) begin
            state_nx    = PLAY;
            score_nx    = 16'h0000;
            new_high_nx = 1'b0;
        end else if (state == PLAY) begin
            score_nx = cand;
            if (go_rise) begin
                state_nx    = OVER;
                high_nx     = cand > high ? cand : high;
                new_high_nx = cand > high;
            end
        end
    end
    always_ff @(posedge score_clk or negedge rst_n)
        if (!rst_n) begin
            state    <= PLAY;
            score    <= 16'h0000;
            high     <= 16'h0000;
            inc_q    <= 1'b0;
            go_q     <= 1'b0;
            new_high <= 1'b0;
        end else begin
            state    <= state_nx;
            score    <= score_nx;
            high     <= high_nx;
            inc_q    <= inc;
            go_q     <= game_over;
            new_high <= new_high_nx;
        end
    assign disp = show_high ? high : score;
    assign {points_3, points_2, points_1, points_0} = disp;
endmodule
